// File: rtl/pattern_driver_pkg.sv
// pattern_driver_pkg: field map and off-state levels shared by the pattern
// driver and its two-bank register file.
//   f_*        : field index of each per-phase pattern field
//   num_fields : number of fields for a given tweak count
//   OFF_*      : bit levels driven while the pads are in the off state
package pattern_driver_pkg;

    localparam logic        OFF_P_LEVEL   = 1'b1;
    localparam logic        OFF_N_LEVEL   = 1'b0;
    localparam logic        OFF_AUX_LEVEL = 1'b0;
    localparam int unsigned DEAD_CNT_W    = 4;

    function automatic int unsigned f_pdrive();
        return 0;
    endfunction

    function automatic int unsigned f_ndrive();
        return 1;
    endfunction

    function automatic int unsigned f_psense();
        return 2;
    endfunction

    function automatic int unsigned f_pdelay();
        return 3;
    endfunction

    function automatic int unsigned f_ptweak(input int unsigned k);
        return 4 + k;
    endfunction

    function automatic int unsigned f_nsense(input int unsigned num_tweak);
        return 4 + num_tweak;
    endfunction

    function automatic int unsigned f_ndelay(input int unsigned num_tweak);
        return 5 + num_tweak;
    endfunction

    function automatic int unsigned f_ntweak(input int unsigned num_tweak, input int unsigned k);
        return 6 + num_tweak + k;
    endfunction

    function automatic int unsigned num_fields(input int unsigned num_tweak);
        return 6 + 2 * num_tweak;
    endfunction

endpackage

// File: rtl/pattern_bank.sv
// pattern_bank: two-bank NUM_FIELDS x WIDTH pattern register file.
//   bank_sel    : index of the active bank; the other bank is the shadow
//   wr_*        : shadow-bank write port, out-of-range addresses ignored
//   rd_*        : registered read port, rd_bank_sel 0 = active, 1 = shadow;
//                 out-of-range addresses read 0
//   active      : flat active-bank contents, field f at [f*WIDTH +: WIDTH]
module pattern_bank #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_FIELDS = 22,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bank_sel,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic                        rd_bank_sel,
    output logic [WIDTH-1:0]            rd_data,
    output logic [NUM_FIELDS*WIDTH-1:0] active
);

    logic [WIDTH-1:0] mem [2][NUM_FIELDS];
    logic             shadow_sel_c;
    logic             rd_sel_c;
    logic             wr_ok_c;
    logic             rd_ok_c;

    assign shadow_sel_c = ~bank_sel;
    assign rd_sel_c     = bank_sel ^ rd_bank_sel;
    assign wr_ok_c      = wr_en && (32'(wr_addr) < NUM_FIELDS);
    assign rd_ok_c      = 32'(rd_addr) < NUM_FIELDS;

    // Storage and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int f = 0; f < int'(NUM_FIELDS); f++) begin
                    mem[b][f] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_ok_c) begin
                mem[shadow_sel_c][wr_addr] <= wr_data;
            end
            rd_data <= rd_ok_c ? mem[rd_sel_c][rd_addr] : '0;
        end
    end

    // Flatten the active bank for the output stage
    always_comb begin
        active = '0;
        for (int f = 0; f < int'(NUM_FIELDS); f++) begin
            active[f*WIDTH +: WIDTH] = mem[bank_sel][f];
        end
    end

endmodule

// File: rtl/pattern_driver.sv
// pattern_driver: double-buffered pattern store and phase driver for the pat
// processor. The shadow bank is written/read by the processor; a commit arms
// a bank swap taken on the next pwm edge. Drive outputs are registered.
//   clk, rst_n        : clock, async active-low reset
//   pwm               : phase input (1 = high-driving phase), synchronous
//   wr_*, rd_*        : shadow write port, registered read port
//   commit            : arm a bank swap; commit_pending shows it is armed
//   buffer_select     : one-hot phase-age sequence, saturating at the MSB
//   p_drive .. tweak_drive : registered pad drive outputs
// Build option: define PATTERN_DRIVER_DEADTIME_EN to insert DEAD_CYCLES of
// off state after each pwm edge; otherwise outputs follow ph directly.
module pattern_driver
    import pattern_driver_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned NUM_TWEAK   = 8,
    parameter  int unsigned NUM_SEL     = 8,
    parameter  int unsigned DEAD_CYCLES = 2,
    localparam int unsigned NUM_FIELDS  = num_fields(NUM_TWEAK),
    localparam int unsigned ADDR_W      = $clog2(NUM_FIELDS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pwm,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_bank_sel,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       commit,
    output logic                       commit_pending,
    output logic [NUM_SEL-1:0]         buffer_select,
    output logic [WIDTH-1:0]           p_drive,
    output logic [WIDTH-1:0]           n_drive,
    output logic [WIDTH-1:0]           tweak_sense,
    output logic [WIDTH-1:0]           tweak_delay,
    output logic [NUM_TWEAK*WIDTH-1:0] tweak_drive
);

    if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > 15)) begin : g_dead_cycles_range
        $error("pattern_driver: DEAD_CYCLES must be in 1..15");
    end

    localparam logic [NUM_SEL-1:0] SEL_RESET = NUM_SEL'(1) << (NUM_SEL - 1);

    logic                        ph;
    logic                        active_sel;
    logic                        pwm_edge_c;
    logic                        swap_c;
    logic                        off_c;
    logic [NUM_FIELDS*WIDTH-1:0] active_bus;

    logic [WIDTH-1:0]            nxt_p_c;
    logic [WIDTH-1:0]            nxt_n_c;
    logic [WIDTH-1:0]            nxt_sense_c;
    logic [WIDTH-1:0]            nxt_delay_c;
    logic [NUM_TWEAK*WIDTH-1:0]  nxt_tweak_c;

    assign pwm_edge_c = pwm != ph;
    // Swap only when armed: by an earlier commit or one in this very cycle
    assign swap_c     = pwm_edge_c && (commit_pending || commit);

    pattern_bank #(
        .WIDTH      (WIDTH),
        .NUM_FIELDS (NUM_FIELDS),
        .ADDR_W     (ADDR_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .bank_sel    (active_sel),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_bank_sel (rd_bank_sel),
        .rd_data     (rd_data),
        .active      (active_bus)
    );

`ifdef PATTERN_DRIVER_DEADTIME_EN
    localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD = DEAD_CNT_W'(DEAD_CYCLES - 1);

    logic [DEAD_CNT_W-1:0] dead_cnt;

    // Dead-time counter: reloads on every edge, so a new edge restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt <= '0;
        end else if (pwm_edge_c) begin
            dead_cnt <= DEAD_LOAD;
        end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DEAD_CNT_W'(1);
        end
    end

    assign off_c = pwm_edge_c || (dead_cnt != '0);
`else
    assign off_c = 1'b0;
`endif

    // Next drive values from the current phase and active bank
    always_comb begin
        nxt_p_c     = {WIDTH{OFF_P_LEVEL}};
        nxt_n_c     = {WIDTH{OFF_N_LEVEL}};
        nxt_sense_c = {WIDTH{OFF_AUX_LEVEL}};
        nxt_delay_c = {WIDTH{OFF_AUX_LEVEL}};
        nxt_tweak_c = {(NUM_TWEAK*WIDTH){OFF_AUX_LEVEL}};
        if (!off_c) begin
            if (ph) begin
                nxt_p_c     = active_bus[f_pdrive()*WIDTH +: WIDTH];
                nxt_sense_c = active_bus[f_psense()*WIDTH +: WIDTH];
                nxt_delay_c = active_bus[f_pdelay()*WIDTH +: WIDTH];
                for (int k = 0; k < int'(NUM_TWEAK); k++) begin
                    nxt_tweak_c[k*WIDTH +: WIDTH] =
                        active_bus[f_ptweak(32'(k))*WIDTH +: WIDTH];
                end
            end else begin
                nxt_n_c     = active_bus[f_ndrive()*WIDTH +: WIDTH];
                nxt_sense_c = active_bus[f_nsense(NUM_TWEAK)*WIDTH +: WIDTH];
                nxt_delay_c = active_bus[f_ndelay(NUM_TWEAK)*WIDTH +: WIDTH];
                for (int k = 0; k < int'(NUM_TWEAK); k++) begin
                    nxt_tweak_c[k*WIDTH +: WIDTH] =
                        active_bus[f_ntweak(NUM_TWEAK, 32'(k))*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Phase tracking, bank swap, age sequence and registered drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph             <= 1'b0;
            active_sel     <= 1'b0;
            commit_pending <= 1'b0;
            buffer_select  <= SEL_RESET;
            p_drive        <= {WIDTH{OFF_P_LEVEL}};
            n_drive        <= {WIDTH{OFF_N_LEVEL}};
            tweak_sense    <= {WIDTH{OFF_AUX_LEVEL}};
            tweak_delay    <= {WIDTH{OFF_AUX_LEVEL}};
            tweak_drive    <= {(NUM_TWEAK*WIDTH){OFF_AUX_LEVEL}};
        end else begin
            ph <= pwm;
            if (swap_c) begin
                active_sel <= ~active_sel;
            end
            if (pwm_edge_c) begin
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
            if (pwm_edge_c) begin
                buffer_select <= NUM_SEL'(1);
            end else if (!buffer_select[NUM_SEL-1]) begin
                buffer_select <= buffer_select << 1;
            end
            p_drive     <= nxt_p_c;
            n_drive     <= nxt_n_c;
            tweak_sense <= nxt_sense_c;
            tweak_delay <= nxt_delay_c;
            tweak_drive <= nxt_tweak_c;
        end
    end

endmodule

// File: tb/tb_pattern_driver.sv
// tb_pattern_driver: directed self-checking bench for pattern_driver at
// default parameters; expectations adapt to PATTERN_DRIVER_DEADTIME_EN.
module tb_pattern_driver;

`ifdef PATTERN_DRIVER_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  rd_addr;
    logic        rd_bank_sel;
    logic [7:0]  rd_data;
    logic        commit;
    logic        commit_pending;
    logic [7:0]  buffer_select;
    logic [7:0]  p_drive;
    logic [7:0]  n_drive;
    logic [7:0]  tweak_sense;
    logic [7:0]  tweak_delay;
    logic [63:0] tweak_drive;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_driver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwm            (pwm),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_addr        (rd_addr),
        .rd_bank_sel    (rd_bank_sel),
        .rd_data        (rd_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .buffer_select  (buffer_select),
        .p_drive        (p_drive),
        .n_drive        (n_drive),
        .tweak_sense    (tweak_sense),
        .tweak_delay    (tweak_delay),
        .tweak_drive    (tweak_drive)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [4:0] wr_addr;
        logic [7:0] wr_data;
        logic [4:0] rd_addr;
        logic       rd_bank_sel;
        logic       commit;
        logic [7:0] exp_rd;
        logic       exp_cp;
        logic [7:0] exp_p;
        logic [7:0] exp_n;
        logic [7:0] exp_bs;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [7:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        logic [7:0] exp_p_d[4];
        logic [7:0] exp_s_d[4];
        logic [7:0] exp_bs_d[4];

        // rows run with pwm held low: {wr_en, wr_addr, wr_data, rd_addr, rd_sel, commit,
        //                              rd, commit_pending, p, n, buffer_select}
        tbl[0] = '{1'b1, 5'd0,  8'h5A, 5'd0,  1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[1] = '{1'b1, 5'd1,  8'hA5, 5'd0,  1'b1, 1'b0, 8'h5A, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[2] = '{1'b0, 5'd0,  8'h00, 5'd1,  1'b1, 1'b0, 8'hA5, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[3] = '{1'b0, 5'd0,  8'h00, 5'd1,  1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[4] = '{1'b1, 5'd22, 8'h77, 5'd22, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[5] = '{1'b0, 5'd0,  8'h00, 5'd0,  1'b1, 1'b0, 8'h5A, 1'b0, 8'hFF, 8'h00, 8'h80};
        tbl[6] = '{1'b0, 5'd0,  8'h00, 5'd22, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h80};
        tbl[7] = '{1'b0, 5'd0,  8'h00, 5'd0,  1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h80};

        rst_n = 1'b0;
        pwm = 1'b0;
        set_wr(1'b0, 5'd0, 8'h00);
        rd_addr = 5'd0;
        rd_bank_sel = 1'b0;
        commit = 1'b0;
        repeat (3) tick();

        // reset values
        chk("reset p_drive", 64'(p_drive), 64'hFF);
        chk("reset n_drive", 64'(n_drive), 64'h00);
        chk("reset buffer_select", 64'(buffer_select), 64'h80);
        chk("reset rd_data", 64'(rd_data), 64'h00);
        chk("reset commit_pending", 64'(commit_pending), 64'h0);
        chk("reset tweak_drive", tweak_drive, 64'h0);
        rst_n = 1'b1;
        tick();

        // shadow writes, reads, out-of-range access, commit arming
        for (int i = 0; i < 8; i++) begin
            set_wr(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data);
            rd_addr = tbl[i].rd_addr;
            rd_bank_sel = tbl[i].rd_bank_sel;
            commit = tbl[i].commit;
            tick();
            chk($sformatf("row%0d rd_data", i), 64'(rd_data), 64'(tbl[i].exp_rd));
            chk($sformatf("row%0d commit_pending", i), 64'(commit_pending), 64'(tbl[i].exp_cp));
            chk($sformatf("row%0d p_drive", i), 64'(p_drive), 64'(tbl[i].exp_p));
            chk($sformatf("row%0d n_drive", i), 64'(n_drive), 64'(tbl[i].exp_n));
            chk($sformatf("row%0d buffer_select", i), 64'(buffer_select), 64'(tbl[i].exp_bs));
        end
        set_wr(1'b0, 5'd0, 8'h00);
        commit = 1'b0;

        // pending swap taken on 0->1 edge at posedge k
        pwm = 1'b1;
        rd_addr = 5'd0;
        rd_bank_sel = 1'b0;
        tick();
        chk("A k commit_pending", 64'(commit_pending), 64'h0);
        chk("A k buffer_select", 64'(buffer_select), 64'h01);
        chk("A k p_drive", 64'(p_drive), 64'hFF);
        chk("A k n_drive", 64'(n_drive), 64'h00);
        tick();
        chk("A k+1 p_drive", 64'(p_drive), DT ? 64'hFF : 64'h5A);
        chk("A k+1 buffer_select", 64'(buffer_select), 64'h02);
        tick();
        chk("A k+2 p_drive", 64'(p_drive), 64'h5A);
        chk("A k+2 n_drive", 64'(n_drive), 64'h00);
        chk("A k+2 buffer_select", 64'(buffer_select), 64'h04);
        chk("A active addr0", 64'(rd_data), 64'h5A);
        rd_bank_sel = 1'b1;
        tick();
        chk("A new shadow addr0", 64'(rd_data), 64'h00);

        // shadow write without commit does not reach outputs
        set_wr(1'b1, 5'd17, 8'h3C);
        tick();
        set_wr(1'b0, 5'd0, 8'h00);
        rd_addr = 5'd17;
        rd_bank_sel = 1'b1;
        tick();
        chk("B shadow ntweak3", 64'(rd_data), 64'h3C);
        pwm = 1'b0;
        repeat (4) tick();
        chk("B p_drive", 64'(p_drive), 64'hFF);
        chk("B n_drive", 64'(n_drive), 64'hA5);
        chk("B tweak_drive", tweak_drive, 64'h0);
        chk("B commit_pending", 64'(commit_pending), 64'h0);

        // commit and edge in the same cycle, write in the swap cycle
        set_wr(1'b1, 5'd6, 8'h11);
        tick();
        set_wr(1'b1, 5'd2, 8'h22);
        tick();
        set_wr(1'b1, 5'd12, 8'h33);
        tick();
        set_wr(1'b1, 5'd3, 8'h44);
        commit = 1'b1;
        pwm = 1'b1;
        tick();
        chk("C swap commit_pending", 64'(commit_pending), 64'h0);
        chk("C swap buffer_select", 64'(buffer_select), 64'h01);
        set_wr(1'b0, 5'd0, 8'h00);
        commit = 1'b0;
        rd_addr = 5'd17;
        rd_bank_sel = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("C buffer_select +%0d", i), 64'(buffer_select),
                (i < 8) ? (64'h1 << i) : 64'h80);
        end
        chk("C p_drive", 64'(p_drive), 64'h00);
        chk("C n_drive", 64'(n_drive), 64'h00);
        chk("C tweak_sense", 64'(tweak_sense), 64'h22);
        chk("C tweak_delay", 64'(tweak_delay), 64'h44);
        chk("C tweak_drive", tweak_drive, 64'h0000_0000_0011_0000);
        chk("C active ntweak3", 64'(rd_data), 64'h3C);

        // second edge one cycle into dead time
        if (DT) begin
            exp_p_d = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
            exp_s_d = '{8'h00, 8'h00, 8'h00, 8'h22};
        end else begin
            exp_p_d = '{8'h00, 8'hFF, 8'h00, 8'h00};
            exp_s_d = '{8'h22, 8'h33, 8'h22, 8'h22};
        end
        exp_bs_d = '{8'h01, 8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 4; i++) begin
            pwm = (i == 0) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("D m+%0d p_drive", i), 64'(p_drive), 64'(exp_p_d[i]));
            chk($sformatf("D m+%0d tweak_sense", i), 64'(tweak_sense), 64'(exp_s_d[i]));
            chk($sformatf("D m+%0d n_drive", i), 64'(n_drive), 64'h00);
            chk($sformatf("D m+%0d buffer_select", i), 64'(buffer_select), 64'(exp_bs_d[i]));
        end

        // mid-phase reset drops a pending commit and restores reset values
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("E commit_pending armed", 64'(commit_pending), 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("E rst commit_pending", 64'(commit_pending), 64'h0);
        chk("E rst p_drive", 64'(p_drive), 64'hFF);
        chk("E rst tweak_sense", 64'(tweak_sense), 64'h00);
        chk("E rst buffer_select", 64'(buffer_select), 64'h80);
        chk("E rst rd_data", 64'(rd_data), 64'h00);
        chk("E rst tweak_drive", tweak_drive, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("E post p_drive", 64'(p_drive), 64'h00);
        chk("E post commit_pending", 64'(commit_pending), 64'h0);
        chk("E post tweak_sense", 64'(tweak_sense), 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
